// File: rtl/ifq_pkg.sv
// ifq_pkg: shared definitions for the instruction fetch queue.
//   DEF_LINE_INSTRS - default instructions per cache line
//   LINE_BYTES      - bytes per line for the default configuration
//   OFF_W           - word-offset width for the default configuration
//   slot_sel()      - maps (read pointer, offset, slot) to (line index, word index)
package ifq_pkg;

    localparam int unsigned DEF_LINE_INSTRS = 4;
    localparam int unsigned LINE_BYTES      = 4 * DEF_LINE_INSTRS;
    localparam int unsigned OFF_W           = $clog2(DEF_LINE_INSTRS);

    typedef struct packed {
        logic [31:0] line;
        logic [31:0] word;
    } slot_sel_t;

    // Slots run past the end of the head line into the following entries.
    function automatic slot_sel_t slot_sel(input int unsigned rp, input int unsigned off,
                                           input int unsigned k, input int unsigned line_instrs,
                                           input int unsigned depth);
        slot_sel_t   s;
        int unsigned pos;
        pos    = off + k;
        s.line = (rp + pos / line_instrs) % depth;
        s.word = pos % line_instrs;
        return s;
    endfunction

endpackage

// File: rtl/ifq_line_buf.sv
// ifq_line_buf: line storage for the fetch queue.
//   clk      - clock
//   we       - write enable
//   waddr    - entry written
//   wdata    - whole cache line, word 0 in the LSBs
//   rd_line  - per-slot entry index
//   rd_word  - per-slot word index within the entry
//   rd_data  - per-slot instruction word (combinational)
// Contents need no reset: unused entries are masked by the read control.
module ifq_line_buf #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LINE_INSTRS = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ISSUE_W     = 2
) (
    input  logic                                             clk,
    input  logic                                             we,
    input  logic [$clog2(FIFO_DEPTH)-1:0]                    waddr,
    input  logic [DATA_WIDTH*LINE_INSTRS-1:0]                wdata,
    input  logic [ISSUE_W-1:0][$clog2(FIFO_DEPTH)-1:0]       rd_line,
    input  logic [ISSUE_W-1:0][$clog2(LINE_INSTRS)-1:0]      rd_word,
    output logic [ISSUE_W-1:0][DATA_WIDTH-1:0]               rd_data
);

    logic [DATA_WIDTH*LINE_INSTRS-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            rd_data[k] = mem[rd_line[k]][int'(rd_word[k]) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/ifq_multi.sv
// ifq_multi: multi-issue instruction fetch queue holding whole cache lines.
//   clk, rst        - clock, asynchronous active-high reset
//   line_i          - cache line for fetch_pc_o, line_valid_i qualifies it
//   redirect_i      - flush and restart at redirect_pc_i (word-aligned)
//   deq_i           - slots consumed this cycle
//   fetch_pc_o      - line address to the cache, fetch_req_o = queue can accept
//   instr_o, pc_o   - ISSUE_W slots, instr_valid_o thermometer from slot 0
//   abort_o         - one-cycle pulse after a redirect
//   empty_o, full_o - no valid words / FIFO_DEPTH lines held
// Optional feature macro IFQ_BYPASS_EN: a line accepted into an empty queue is
// presented in the same cycle and may be dequeued immediately.
module ifq_multi
    import ifq_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          LINE_INSTRS = DEF_LINE_INSTRS,
    parameter int unsigned          FIFO_DEPTH  = 4,
    parameter int unsigned          ISSUE_W     = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH*LINE_INSTRS-1:0] line_i,
    input  logic                              line_valid_i,
    input  logic                              redirect_i,
    input  logic [DATA_WIDTH-1:0]             redirect_pc_i,
    input  logic [$clog2(ISSUE_W+1)-1:0]      deq_i,
    output logic [DATA_WIDTH-1:0]             fetch_pc_o,
    output logic                              fetch_req_o,
    output logic [ISSUE_W*DATA_WIDTH-1:0]     instr_o,
    output logic [ISSUE_W*DATA_WIDTH-1:0]     pc_o,
    output logic [ISSUE_W-1:0]                instr_valid_o,
    output logic                              abort_o,
    output logic                              empty_o,
    output logic                              full_o
);

    localparam int unsigned OW  = $clog2(LINE_INSTRS);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DQW = $clog2(ISSUE_W + 1);
    localparam int unsigned AW  = $clog2(LINE_INSTRS * FIFO_DEPTH + 1);
    localparam int unsigned LB  = 4 * LINE_INSTRS;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [PW-1:0]         rp_q, rp_d, wp_q, wp_d;
    logic [CW-1:0]         count_q, count_d;
    logic [OW-1:0]         off_q, off_d;
    logic                  abort_q;

    logic                  accept, bypass, we;
    logic [PW-1:0]         waddr;
    logic [AW-1:0]         avail;
    logic [DQW-1:0]        n_valid;
    logic [OW:0]           off_sum;
    logic                  pop;

    logic [ISSUE_W-1:0][PW-1:0]         rd_line;
    logic [ISSUE_W-1:0][OW-1:0]         rd_word;
    logic [ISSUE_W-1:0][DATA_WIDTH-1:0] rd_data;

    // With an empty queue off may still hold a redirect target word, so clamp.
    assign avail = (count_q == '0) ? '0
                 : AW'(count_q) * AW'(LINE_INSTRS) - AW'(off_q);

    assign full_o      = (count_q == CW'(FIFO_DEPTH));
    assign empty_o     = (avail == '0);
    assign abort_o     = abort_q;
    assign fetch_req_o = ~full_o;
    assign fetch_pc_o  = redirect_i ? (redirect_pc_i & ~DATA_WIDTH'(LB - 1)) : fetch_pc_q;

    // A redirect always takes its target line, even when full.
    assign accept = line_valid_i & (redirect_i | ~full_o);

`ifdef IFQ_BYPASS_EN
    assign bypass = empty_o & ~redirect_i & accept;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        slot_sel_t sel;
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            sel        = slot_sel(int'(rp_q), int'(off_q), k, LINE_INSTRS, FIFO_DEPTH);
            rd_line[k] = PW'(sel.line);
            rd_word[k] = OW'(sel.word);
        end
    end

    ifq_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_INSTRS(LINE_INSTRS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ISSUE_W    (ISSUE_W)
    ) u_line_buf (
        .clk    (clk),
        .we     (we),
        .waddr  (waddr),
        .wdata  (line_i),
        .rd_line(rd_line),
        .rd_word(rd_word),
        .rd_data(rd_data)
    );

    // Slot outputs; in bypass the words come straight from line_i.
    always_comb begin
        logic                  v;
        logic [DATA_WIDTH-1:0] w;
        instr_o       = '0;
        pc_o          = '0;
        instr_valid_o = '0;
        n_valid       = '0;
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            if (bypass) begin
                v = (int'(LINE_INSTRS) - int'(off_q)) > k;
                w = line_i[int'(rd_word[k]) * DATA_WIDTH +: DATA_WIDTH];
            end else begin
                v = int'(avail) > k;
                w = rd_data[k];
            end
            v = v & ~redirect_i;
            instr_valid_o[k]                    = v;
            instr_o[k*DATA_WIDTH +: DATA_WIDTH] = v ? w : '0;
            pc_o[k*DATA_WIDTH +: DATA_WIDTH]    = head_pc_q + DATA_WIDTH'(4 * k);
            if (v) begin
                n_valid = n_valid + DQW'(1);
            end
        end
    end

    always_comb begin
        rp_d       = rp_q;
        wp_d       = wp_q;
        count_d    = count_q;
        off_d      = off_q;
        head_pc_d  = head_pc_q;
        fetch_pc_d = accept ? fetch_pc_o + DATA_WIDTH'(LB) : fetch_pc_o;
        we         = 1'b0;
        waddr      = wp_q;
        off_sum    = (OW+1)'(off_q) + (OW+1)'(deq_i);
        // deq_i never exceeds LINE_INSTRS, so at most one line is crossed.
        pop        = off_sum[OW];

        if (redirect_i) begin
            rp_d      = '0;
            off_d     = redirect_pc_i[OW+1:2];
            head_pc_d = redirect_pc_i;
            we        = accept;
            waddr     = '0;
            wp_d      = accept ? PW'(1) : '0;
            count_d   = accept ? CW'(1) : '0;
        end else begin
            off_d     = off_sum[OW-1:0];
            head_pc_d = head_pc_q + (DATA_WIDTH'(deq_i) << 2);
            if (bypass) begin
                // Line fully consumed on arrival: nothing to keep.
                if (!pop) begin
                    we      = 1'b1;
                    wp_d    = wp_q + PW'(1);
                    count_d = CW'(1);
                end
            end else begin
                we      = accept;
                wp_d    = wp_q + PW'(accept);
                rp_d    = rp_q + PW'(pop);
                count_d = count_q + CW'(accept) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            rp_q       <= '0;
            wp_q       <= '0;
            count_q    <= '0;
            off_q      <= '0;
            abort_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            count_q    <= count_d;
            off_q      <= off_d;
            abort_q    <= redirect_i;
        end
    end

    deq_le_valid: assert property (@(posedge clk) disable iff (rst)
        !redirect_i |-> (deq_i <= n_valid));

endmodule

// File: tb/tb_ifq_multi.sv
module tb_ifq_multi;
    import ifq_pkg::*;

    localparam int DW    = 32;
    localparam int LI    = 1 << OFF_W;
    localparam int LBY   = LINE_BYTES;
    localparam int DEPTH = 4;
    localparam int IW    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW*LI-1:0]  line_i = '0;
    logic              line_valid_i = 1'b0;
    logic              redirect_i = 1'b0;
    logic [DW-1:0]     redirect_pc_i = '0;
    logic [1:0]        deq_i = '0;
    logic [DW-1:0]     fetch_pc_o;
    logic              fetch_req_o;
    logic [IW*DW-1:0]  instr_o;
    logic [IW*DW-1:0]  pc_o;
    logic [IW-1:0]     instr_valid_o;
    logic              abort_o, empty_o, full_o;

    ifq_multi #(
        .DATA_WIDTH (DW),
        .LINE_INSTRS(LI),
        .FIFO_DEPTH (DEPTH),
        .ISSUE_W    (IW),
        .RESET_PC   ('0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .line_i       (line_i),
        .line_valid_i (line_valid_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .deq_i        (deq_i),
        .fetch_pc_o   (fetch_pc_o),
        .fetch_req_o  (fetch_req_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .instr_valid_o(instr_valid_o),
        .abort_o      (abort_o),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // Reference model: a flat queue of pending instruction words plus the head PC.
    logic [31:0] wq[$];
    logic [31:0] m_head, m_fetch;
    bit          m_abort;

    function automatic int m_off();
        return int'((m_head >> 2) % LI);
    endfunction

    function automatic int m_lines();
        if (wq.size() == 0) return 0;
        return (wq.size() + m_off() + LI - 1) / LI;
    endfunction

    task automatic m_reset();
        wq.delete();
        m_head  = '0;
        m_fetch = '0;
        m_abort = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_fetch_pc"}, fetch_pc_o, 32'h0);
        check({pfx, "_fetch_req"}, fetch_req_o, 1);
        check({pfx, "_abort"}, abort_o, 0);
        check({pfx, "_empty"}, empty_o, 1);
        check({pfx, "_full"}, full_o, 0);
        check({pfx, "_valid"}, instr_valid_o, 0);
        check({pfx, "_instr0"}, instr_o[31:0], 0);
        check({pfx, "_instr1"}, instr_o[63:32], 0);
    endtask

    // One cycle: deq_req < 0 picks a random legal dequeue count.
    task automatic step(input bit lv, input bit rd, input logic [31:0] rpc, input int deq_req);
        logic [31:0] words[LI];
        logic [31:0] view[$];
        logic [31:0] fpc;
        bit          full_e, acc, byp, v;
        int          nv, dq, st;

        @(negedge clk);
        fpc    = rd ? (rpc & ~32'(LBY - 1)) : m_fetch;
        full_e = (m_lines() == DEPTH);
        acc    = lv && (rd || !full_e);
        for (int w = 0; w < LI; w++) words[w] = $urandom;
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = !rd && (wq.size() == 0) && acc;
`endif
        if (byp) begin
            for (int w = m_off(); w < LI; w++) view.push_back(words[w]);
        end else begin
            view = wq;
        end
        nv = rd ? 0 : ((view.size() < IW) ? view.size() : IW);
        if (deq_req < 0) dq = int'($urandom_range(nv, 0));
        else dq = (deq_req < nv) ? deq_req : nv;

        for (int w = 0; w < LI; w++) line_i[w*DW +: DW] = words[w];
        line_valid_i  = lv;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        deq_i         = 2'(dq);
        #1;
        check("fetch_pc", fetch_pc_o, fpc);
        check("fetch_req", fetch_req_o, !full_e);
        check("abort", abort_o, m_abort);
        check("empty", empty_o, wq.size() == 0);
        check("full", full_o, full_e);
        for (int k = 0; k < IW; k++) begin
            v = (k < nv);
            check($sformatf("valid%0d", k), instr_valid_o[k], v);
            check($sformatf("instr%0d", k), instr_o[k*DW +: DW], v ? view[k] : 32'h0);
            if (v) check($sformatf("pc%0d", k), pc_o[k*DW +: DW], m_head + 32'(4 * k));
        end

        m_abort = rd;
        if (rd) begin
            wq.delete();
            m_head = rpc;
            if (acc) for (int w = m_off(); w < LI; w++) wq.push_back(words[w]);
        end else begin
            if (byp) begin
                wq = view;
            end else if (acc) begin
                st = (wq.size() == 0) ? m_off() : 0;
                for (int w = st; w < LI; w++) wq.push_back(words[w]);
            end
            for (int i = 0; i < dq; i++) void'(wq.pop_front());
            m_head = m_head + 32'(4 * dq);
        end
        m_fetch = acc ? fpc + 32'(LBY) : fpc;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        line_valid_i = 1'b0;
        redirect_i   = 1'b0;
        deq_i        = '0;
        rst          = 1'b1;
        #1;
        check_reset_outputs("arst");
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_reset();
        #13;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // Stream two lines, dequeuing two per cycle.
        step(1, 0, 0, 2);
        step(1, 0, 0, 2);
        step(0, 0, 0, 2);
        step(0, 0, 0, 2);
        step(0, 0, 0, 2);
        // Fill to full, a fifth line is refused.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 2);
        step(0, 0, 0, 2);
        step(1, 0, 0, 0);
        // Redirect while full, then cross a line boundary.
        step(1, 1, 32'h108, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 2);
        step(0, 0, 0, 2);
        // Redirect without a line, then the target line arrives.
        step(0, 1, 32'h20c, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, -1);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            step(($urandom % 10) < 7, ($urandom % 16) == 0, $urandom & 32'h0000_0ffc, -1);
        end
        async_reset();
        step(1, 0, 0, 2);
        step(0, 0, 0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
